// File: rtl/qtable_packet_tx_if.sv
// Outgoing packet word stream: 16-bit words with valid/ready handshake and a last-word marker.
interface qtable_packet_tx_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_last;

  modport master (output tx_data, tx_valid, tx_last, input tx_ready);
  modport slave  (input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/qtable_packet_tx.sv
// Scans the neighbor table for the best next hop, then serializes a 7-word advert packet.
module qtable_packet_tx #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myHops,
  input  logic [WORD_WIDTH-1:0] myClusterID,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [2:0]            pktType,
  input  logic [WORD_WIDTH-1:0] neighborCount,
  output logic [IDX_WIDTH-1:0]  rd_index,
  input  logic [WORD_WIDTH-1:0] rdSourceID,
  input  logic [WORD_WIDTH-1:0] rdSourceHops,
  input  logic [WORD_WIDTH-1:0] rdQValue,
  qtable_packet_tx_if.master    tx,
  output logic                  busy,
  output logic                  done,
  output logic                  noRoute
);

  localparam int unsigned CntWidth  = IDX_WIDTH + 1;
  localparam int unsigned TableSize = 1 << IDX_WIDTH;

  typedef enum logic [1:0] {StIdle, StScan, StSend, StDone} state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   n_q;
  logic                  issue_q;  // rd_index holds a live address this cycle
  logic                  cmp_q;    // read data for the previous address is present
  logic [WORD_WIDTH-1:0] node_id_q, hops_q, cluster_q, energy_q;
  logic [2:0]            pkt_type_q;
  logic [WORD_WIDTH-1:0] best_id_q, best_hops_q, best_qv_q;
  logic                  best_valid_q;
  logic [2:0]            word_q;

  logic [CntWidth-1:0]   n_start;
  logic [CntWidth-1:0]   last_idx;
  logic                  take_new;
  logic [2:0]            word_nxt;
  logic [WORD_WIDTH-1:0] pkt_word;
  logic [WORD_WIDTH-1:0] word_nxt_data;

  always_comb begin
    n_start  = (neighborCount > WORD_WIDTH'(TableSize)) ? CntWidth'(TableSize)
                                                        : neighborCount[CntWidth-1:0];
    last_idx = n_q - CntWidth'(1);
    take_new = !best_valid_q || (rdQValue > best_qv_q) ||
               ((rdQValue == best_qv_q) && (rdSourceHops < best_hops_q));
    word_nxt = word_q + 3'd1;
    pkt_word = {{(WORD_WIDTH-3){1'b0}}, pkt_type_q};
    case (word_nxt)
      3'd1:    word_nxt_data = best_id_q;
      3'd2:    word_nxt_data = node_id_q;
      3'd3:    word_nxt_data = hops_q;
      3'd4:    word_nxt_data = cluster_q;
      3'd5:    word_nxt_data = energy_q;
      3'd6:    word_nxt_data = best_qv_q;
      default: word_nxt_data = pkt_word;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StIdle;
      n_q          <= '0;
      issue_q      <= 1'b0;
      cmp_q        <= 1'b0;
      node_id_q    <= '0;
      hops_q       <= '0;
      cluster_q    <= '0;
      energy_q     <= '0;
      pkt_type_q   <= '0;
      best_id_q    <= '1;
      best_hops_q  <= '1;
      best_qv_q    <= '0;
      best_valid_q <= 1'b0;
      word_q       <= '0;
      rd_index     <= '0;
      tx.tx_data   <= '0;
      tx.tx_valid  <= 1'b0;
      tx.tx_last   <= 1'b0;
      done         <= 1'b0;
      noRoute      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) begin
            node_id_q    <= myNodeID;
            hops_q       <= myHops;
            cluster_q    <= myClusterID;
            energy_q     <= myEnergy;
            pkt_type_q   <= pktType;
            n_q          <= n_start;
            issue_q      <= (n_start != '0);
            cmp_q        <= 1'b0;
            rd_index     <= '0;
            best_id_q    <= '1;
            best_hops_q  <= '1;
            best_qv_q    <= '0;
            best_valid_q <= 1'b0;
            noRoute      <= 1'b0;
            state_q      <= StScan;
          end
        end
        StScan: begin
          if (cmp_q && take_new) begin
            best_id_q    <= rdSourceID;
            best_hops_q  <= rdSourceHops;
            best_qv_q    <= rdQValue;
            best_valid_q <= 1'b1;
          end
          cmp_q <= issue_q;
          if (issue_q) begin
            if ({1'b0, rd_index} == last_idx) begin
              issue_q <= 1'b0;
            end else begin
              rd_index <= rd_index + IDX_WIDTH'(1);
            end
          end else begin
            // Final compare (if any) completes this cycle; W0 needs no best-entry data.
            noRoute     <= (n_q == '0);
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= pkt_word;
            tx.tx_last  <= 1'b0;
            word_q      <= '0;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (tx.tx_ready) begin
            if (word_q == 3'd6) begin
              tx.tx_valid <= 1'b0;
              tx.tx_data  <= '0;
              tx.tx_last  <= 1'b0;
              done        <= 1'b1;
              state_q     <= StDone;
            end else begin
              word_q     <= word_nxt;
              tx.tx_data <= word_nxt_data;
              tx.tx_last <= (word_nxt == 3'd6);
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_qtable_packet_tx.sv
// Scoreboard bench: expected packets come from a best-hop reference model over the table array.
module tb_qtable_packet_tx;
  localparam int unsigned WW = 16;
  localparam int unsigned IW = 6;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          en = 1'b0;
  logic [WW-1:0] my_node_id = '0, my_hops = '0, my_cluster_id = '0, my_energy = '0;
  logic [2:0]    pkt_type = '0;
  logic [WW-1:0] neighbor_count = '0;
  logic [IW-1:0] rd_index;
  logic [WW-1:0] rd_source_id = '0, rd_source_hops = '0, rd_q_value = '0;
  logic          busy, done, no_route;

  logic [WW-1:0] tbl_id [64];
  logic [WW-1:0] tbl_hops [64];
  logic [WW-1:0] tbl_q [64];

  word_t exp_q [$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    ready_mode = 0;

  int            t0 = 0, first_cyc = -1, done_cyc = -1, stalls = 0, acc_cnt = 0;
  int            max_rd = 0, last_rd = 0;
  bit            wrap_seen = 1'b0, hold_pend = 1'b0;
  logic [WW-1:0] held_data = '0;
  logic          held_last = 1'b0;

  qtable_packet_tx_if #(.WORD_WIDTH(WW)) tx_if ();

  qtable_packet_tx #(.WORD_WIDTH(WW), .IDX_WIDTH(IW)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .myNodeID     (my_node_id),
    .myHops       (my_hops),
    .myClusterID  (my_cluster_id),
    .myEnergy     (my_energy),
    .pktType      (pkt_type),
    .neighborCount(neighbor_count),
    .rd_index     (rd_index),
    .rdSourceID   (rd_source_id),
    .rdSourceHops (rd_source_hops),
    .rdQValue     (rd_q_value),
    .tx           (tx_if),
    .busy         (busy),
    .done         (done),
    .noRoute      (no_route)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous table memory: data appears one cycle after the address.
  always @(posedge clk) begin
    rd_source_id   <= tbl_id[rd_index];
    rd_source_hops <= tbl_hops[rd_index];
    rd_q_value     <= tbl_q[rd_index];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and tracks packet timing.
  always @(negedge clk) begin
    word_t e;
    if (!nrst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (en && !busy) begin
        t0 = cyc; first_cyc = -1; done_cyc = -1; stalls = 0; acc_cnt = 0;
        max_rd = 0; last_rd = 0; wrap_seen = 1'b0;
      end
      if (hold_pend) begin
        check("hold_valid", 32'(tx_if.tx_valid), 32'd1);
        check("hold_data", 32'(tx_if.tx_data), 32'(held_data));
        check("hold_last", 32'(tx_if.tx_last), 32'(held_last));
      end
      hold_pend = tx_if.tx_valid && !tx_if.tx_ready;
      held_data = tx_if.tx_data;
      held_last = tx_if.tx_last;
      if (!tx_if.tx_valid) check("idle_data_zero", 32'(tx_if.tx_data), 32'd0);
      else if (first_cyc < 0) first_cyc = cyc;
      if (hold_pend) stalls++;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %h, expected no word", tx_if.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 32'(tx_if.tx_data), 32'(e.data));
          check("word_last", 32'(tx_if.tx_last), 32'(e.last));
          acc_cnt++;
        end
      end
      if (done) done_cyc = cyc;
      if (busy) begin
        if (int'(rd_index) < last_rd) wrap_seen = 1'b1;
        last_rd = int'(rd_index);
        if (last_rd > max_rd) max_rd = last_rd;
      end
    end
  end

  // Sink ready: always, random, or a 3-cycle stall while the third word is presented.
  initial begin
    int stall_left;
    stall_left = 3;
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (acc_cnt == 0) stall_left = 3;
      case (ready_mode)
        0: tx_if.tx_ready = 1'b1;
        1: tx_if.tx_ready = 1'($urandom_range(0, 1));
        default: begin
          if (tx_if.tx_valid && acc_cnt == 2 && stall_left > 0) begin
            tx_if.tx_ready = 1'b0;
            stall_left--;
          end else begin
            tx_if.tx_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Reference: highest Q, then fewest hops, then lowest index.
  task automatic push_expected(input int n);
    logic [WW-1:0] bid, bq, minh;
    word_t w;
    bid = '1;
    bq  = '0;
    if (n > 0) begin
      for (int i = 0; i < n; i++) if (tbl_q[i] > bq) bq = tbl_q[i];
      minh = '1;
      for (int i = 0; i < n; i++) if (tbl_q[i] == bq && tbl_hops[i] < minh) minh = tbl_hops[i];
      for (int i = n - 1; i >= 0; i--) if (tbl_q[i] == bq && tbl_hops[i] == minh) bid = tbl_id[i];
    end
    w.last = 1'b0;
    w.data = {13'b0, pkt_type}; exp_q.push_back(w);
    w.data = bid;               exp_q.push_back(w);
    w.data = my_node_id;        exp_q.push_back(w);
    w.data = my_hops;           exp_q.push_back(w);
    w.data = my_cluster_id;     exp_q.push_back(w);
    w.data = my_energy;         exp_q.push_back(w);
    w.data = bq; w.last = 1'b1; exp_q.push_back(w);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_index", 32'(rd_index), 32'd0);
    check("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("rst_tx_last", 32'(tx_if.tx_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_no_route", 32'(no_route), 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      tbl_id[i]   = WW'($urandom);
      tbl_hops[i] = WW'($urandom_range(0, 3));
      tbl_q[i]    = WW'($urandom_range(0, 3) << 12);
    end
    my_node_id    = WW'($urandom);
    my_hops       = WW'($urandom);
    my_cluster_id = WW'($urandom);
    my_energy     = WW'($urandom);
    pkt_type      = 3'($urandom);
  endtask

  task automatic set_example();
    tbl_id[0] = 16'd1;  tbl_hops[0] = 16'd2; tbl_q[0] = 16'h3000;
    tbl_id[1] = 16'd17; tbl_hops[1] = 16'd2; tbl_q[1] = 16'hB800;
    pkt_type = 3'b101; my_node_id = 16'd5; my_hops = 16'd3;
    my_cluster_id = 16'd2; my_energy = 16'h8000;
  endtask

  // Called right after a posedge (+1); returns the same way.
  task automatic run_packet(input int n_raw, input bit pulse_mid);
    int n;
    bit got;
    n = (n_raw > 64) ? 64 : n_raw;
    neighbor_count = WW'(n_raw);
    push_expected(n);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    if (pulse_mid) begin
      @(posedge clk); #1;
      en = 1'b1;
      my_node_id = ~my_node_id;
      pkt_type   = ~pkt_type;
      @(posedge clk); #1;
      en = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        en  = 1'b1;  // must be ignored: FSM not yet idle
      end
    end
    check("done_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    en = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    check("first_word_cycle", 32'(first_cyc - t0), 32'(n + 2));
    check("done_cycle", 32'(done_cyc - t0), 32'(n + 9 + stalls));
    check("no_route", 32'(no_route), 32'(n == 0));
    check("all_words_sent", 32'(exp_q.size()), 32'd0);
    check("rd_index_no_wrap", 32'(wrap_seen), 32'd0);
    if (n > 0) check("rd_index_last", 32'(max_rd), 32'(n - 1));
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_send();
    bit got;
    fill_random();
    neighbor_count = 16'd8;
    push_expected(8);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #1;
      if (acc_cnt >= 3) got = 1'b1;
    end
    check("reached_send", 32'(got), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      tbl_id[i] = '0; tbl_hops[i] = '0; tbl_q[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    nrst = 1'b1;
    @(posedge clk); #1;

    set_example();
    run_packet(2, 1'b0);
    run_packet(0, 1'b0);

    tbl_id[0] = 16'd7; tbl_hops[0] = 16'd3; tbl_q[0] = 16'h2000;
    tbl_id[1] = 16'd9; tbl_hops[1] = 16'd1; tbl_q[1] = 16'h2000;
    run_packet(2, 1'b0);
    tbl_hops[1] = 16'd3;
    run_packet(2, 1'b0);

    set_example();
    ready_mode = 2;
    run_packet(2, 1'b0);
    check("bp_stall_cycles", 32'(stalls), 32'd3);
    ready_mode = 0;

    fill_random();
    run_packet(20, 1'b1);

    reset_mid_send();
    fill_random();
    run_packet(8, 1'b0);

    fill_random();
    run_packet(70, 1'b0);

    ready_mode = 1;
    for (int r = 0; r < 20; r++) begin
      fill_random();
      run_packet(int'($urandom_range(0, 70)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
